dino_motion_controller: RTL and testbench
=========================================

// Module: dino_motion_controller
// PURPOSE
//  Game-physics stage directly upstream of VGAController. Turns the up/down
//  buttons into the dino sprite position (dino_x, dino_y), once per frame.
//  Frame tick = rising edge of VGAController's screenEnd. Implements jump
//  (constant gravity), fast-fall and duck. Updates land between frames, so a
//  frame is never drawn with a partly updated position.
// PARAMETERS
//  X_POS       100  fixed dino_x (left edge of sprite, pixels)
//  REST_Y      275  dino_y on ground (GROUND 335 minus 60-px sprite height)
//  JUMP_V      18   initial upward speed, px/frame
//  GRAVITY     1    speed change per frame, px/frame^2
//  MAX_FALL_V  18   falling-speed clamp, px/frame
//  FASTFALL_V  12   falling speed forced when down is pressed mid-rise
// PORTS
//  clk        in   1   100 MHz system clock; single clock domain
//  reset      in   1   asynchronous, active-high
//  screenEnd  in   1   from VGAController, high for several clk between frames
//  up         in   1   raw jump button (asynchronous)
//  down       in   1   raw duck button (asynchronous)
//  halt       in   1   freeze physics (game over / pause)
//  dino_x     out  32  sprite x, to VGAController
//  dino_y     out  32  sprite y, to VGAController
//  ducking    out  1   high while in DUCK
//  airborne   out  1   high in RISE or FALL
// BEHAVIOUR
//  Reset: dino_x=X_POS, dino_y=REST_Y, state=GROUND, vel=0, ducking=0,
//   airborne=0, button synchronisers and jump_req cleared.
//  up and down each pass through a 2-flop synchroniser (up_s, down_s).
//  jump_req: set on any clk with up_s=1; cleared on every tick.
//  tick = screenEnd & ~screenEnd_q. That is exactly one clk per frame. All
//   state, vel and position updates happen only on the tick edge. Outputs
//   are registered and change on that same edge.
//  halt=1: ticks are ignored and every register holds. jump_req stays
//   cleared while halted.
//  vel is 8-bit unsigned. y arithmetic is 32-bit unsigned. dino_x is constant.
//  On a tick, by state:
//   GROUND: down_s -> DUCK. Else (jump_req|up_s) -> RISE, y<=y-JUMP_V,
//    vel<=JUMP_V-GRAVITY. Else hold.
//   DUCK: !down_s -> GROUND. up is ignored while ducking. down has priority
//    when up and down are pressed together.
//   RISE: down_s -> FALL, vel<=FASTFALL_V, y unchanged. Else y<=y-vel,
//    vel<=vel-GRAVITY. If vel-GRAVITY==0 -> FALL with vel=0.
//   FALL: v'=min(vel+GRAVITY, MAX_FALL_V), vel<=v'.
//    If y+v'>=REST_Y: y<=REST_Y, vel<=0, state GROUND (no overshoot).
//    Else y<=y+v'. Landing does not re-jump on the same tick.
//  With the defaults, a jump takes 18 rise ticks, peaks at y=104, and lands
//   at y=275 after 18 fall ticks.
//  Reset mid-jump puts the dino back on the ground at once.
//  screenEnd held high for N clk still gives only one tick.
// STRUCTURE
//  dino_pkg holds: state encoding (GROUND, DUCK, RISE, FALL, 2 bits),
//   GROUND=335, SPRITE_W=SPRITE_H=60.
//  Sub-module frame_tick_gen (clk, reset, screenEnd -> tick): edge detect.
//  The top level holds the synchronisers, jump_req, the FSM and the
//   position datapath.
// TESTING
//  1. Reset, then 5 ticks with no buttons -> dino_x=100, dino_y=275,
//     airborne=0 throughout.
//  2. Pulse up for 3 clk mid-frame, then tick -> y=257, RISE. 18th tick ->
//     y=104, FALL. 36th tick -> y=275, GROUND. Check every intermediate y.
//  3. screenEnd held high 8 clk -> only one position step. halt=1 across
//     3 ticks mid-jump -> y and state unchanged.
//  4. down held on ground -> ducking=1 at next tick. up pressed during
//     DUCK -> no jump. Release down -> GROUND on next tick.
//  5. During RISE at y=200, press down -> FALL with vel=12. Lands at
//     exactly 275 with no overshoot.
//  6. Assert reset while in FALL at y=150 -> y=275 and all outputs at
//     their reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared definitions for the dino motion controller.
//   dino_state_e : motion state encoding (2 bits)
//   GROUND_Y     : screen row of the ground line, in pixels
//   SPRITE_W/H   : dino sprite size, in pixels
package dino_pkg;

    typedef enum logic [1:0] {
        S_GROUND = 2'd0,
        S_DUCK   = 2'd1,
        S_RISE   = 2'd2,
        S_FALL   = 2'd3
    } dino_state_e;

    localparam int unsigned GROUND_Y = 335;
    localparam int unsigned SPRITE_W = 60;
    localparam int unsigned SPRITE_H = 60;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: a one-clk pulse on the rising edge of screenEnd.
//   clk       in  system clock
//   reset     in  asynchronous, active-high
//   screenEnd in  end-of-frame level from the VGA controller (same clock domain)
//   tick      out one clk wide, once per frame
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic screenEnd,
    output logic tick
);

    logic screen_end_q;
    logic screen_end_d;

    always_comb screen_end_d = screenEnd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) screen_end_q <= 1'b0;
        else       screen_end_q <= screen_end_d;
    end

    // A long screenEnd still yields a single tick.
    assign tick = screenEnd & ~screen_end_q;

endmodule

// File: rtl/dino_motion_controller.sv
// Dino motion controller: turns up/down buttons into the sprite position,
// updated once per frame tick so a frame is never drawn mid-update.
//   clk       in  system clock
//   reset     in  asynchronous, active-high
//   screenEnd in  end-of-frame level from the VGA controller
//   up, down  in  raw asynchronous buttons
//   halt      in  freeze physics
//   dino_x    out sprite x (constant)
//   dino_y    out sprite y
//   ducking   out high in DUCK
//   airborne  out high in RISE or FALL
//
// state  | meaning
// GROUND | standing at REST_Y, may jump or duck
// DUCK   | down held on the ground
// RISE   | moving up, speed decreasing by GRAVITY each frame
// FALL   | moving down, speed increasing up to MAX_FALL_V
module dino_motion_controller
    import dino_pkg::*;
#(
    parameter int unsigned X_POS      = 100,
    parameter int unsigned REST_Y     = GROUND_Y - SPRITE_H,
    parameter int unsigned JUMP_V     = 18,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned MAX_FALL_V = 18,
    parameter int unsigned FASTFALL_V = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screenEnd,
    input  logic        up,
    input  logic        down,
    input  logic        halt,
    output logic [31:0] dino_x,
    output logic [31:0] dino_y,
    output logic        ducking,
    output logic        airborne
);

    localparam logic [7:0] JUMP_V8   = 8'(JUMP_V);
    localparam logic [7:0] GRAV8     = 8'(GRAVITY);
    localparam logic [7:0] MAX_FALL8 = 8'(MAX_FALL_V);
    localparam logic [7:0] FAST8     = 8'(FASTFALL_V);

    logic        tick;
    logic        up_meta_q, up_s_q, down_meta_q, down_s_q;
    logic        jump_req_q, jump_req_d;
    dino_state_e state_q, state_d;
    logic [7:0]  vel_q, vel_d;
    logic [31:0] y_q, y_d;
    logic        ducking_q, ducking_d, airborne_q, airborne_d;
    logic [8:0]  vel_inc;
    logic [7:0]  fall_v;
    logic        step;

    frame_tick_gen u_tick (
        .clk       (clk),
        .reset     (reset),
        .screenEnd (screenEnd),
        .tick      (tick)
    );

    assign step = tick & ~halt;

    // Widened so a large vel plus GRAVITY cannot wrap before the clamp.
    assign vel_inc = {1'b0, vel_q} + {1'b0, GRAV8};
    assign fall_v  = (vel_inc > {1'b0, MAX_FALL8}) ? MAX_FALL8 : vel_inc[7:0];

    always_comb begin
        jump_req_d = 1'b0;
        if (!halt && !tick) jump_req_d = jump_req_q | up_s_q;
    end

    always_comb begin
        state_d = state_q;
        vel_d   = vel_q;
        y_d     = y_q;
        if (step) begin
            case (state_q)
                S_GROUND: begin
                    if (down_s_q) begin
                        state_d = S_DUCK;
                    end else if (jump_req_q | up_s_q) begin
                        state_d = S_RISE;
                        y_d     = y_q - 32'(JUMP_V);
                        vel_d   = JUMP_V8 - GRAV8;
                    end
                end
                S_DUCK: begin
                    if (!down_s_q) state_d = S_GROUND;
                end
                S_RISE: begin
                    if (down_s_q) begin
                        state_d = S_FALL;
                        vel_d   = FAST8;
                    end else begin
                        y_d = y_q - {24'd0, vel_q};
                        if (vel_q <= GRAV8) begin
                            state_d = S_FALL;
                            vel_d   = 8'd0;
                        end else begin
                            vel_d = vel_q - GRAV8;
                        end
                    end
                end
                S_FALL: begin
                    // Clamp the landing to REST_Y so the sprite never sinks into the ground.
                    if (y_q + {24'd0, fall_v} >= REST_Y) begin
                        state_d = S_GROUND;
                        y_d     = REST_Y;
                        vel_d   = 8'd0;
                    end else begin
                        y_d   = y_q + {24'd0, fall_v};
                        vel_d = fall_v;
                    end
                end
                default: state_d = S_GROUND;
            endcase
        end
        ducking_d  = (state_d == S_DUCK);
        airborne_d = (state_d == S_RISE) || (state_d == S_FALL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_meta_q   <= 1'b0;
            up_s_q      <= 1'b0;
            down_meta_q <= 1'b0;
            down_s_q    <= 1'b0;
            jump_req_q  <= 1'b0;
            state_q     <= S_GROUND;
            vel_q       <= 8'd0;
            y_q         <= REST_Y;
            ducking_q   <= 1'b0;
            airborne_q  <= 1'b0;
        end else begin
            up_meta_q   <= up;
            up_s_q      <= up_meta_q;
            down_meta_q <= down;
            down_s_q    <= down_meta_q;
            jump_req_q  <= jump_req_d;
            state_q     <= state_d;
            vel_q       <= vel_d;
            y_q         <= y_d;
            ducking_q   <= ducking_d;
            airborne_q  <= airborne_d;
        end
    end

    assign dino_x   = 32'(X_POS);
    assign dino_y   = y_q;
    assign ducking  = ducking_q;
    assign airborne = airborne_q;

endmodule

// File: tb/tb_dino_motion_controller.sv
module tb_dino_motion_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        screenEnd = 1'b0;
    logic        up = 1'b0;
    logic        down = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] dino_x;
    logic [31:0] dino_y;
    logic        ducking;
    logic        airborne;

    int n_tests = 0;
    int n_fail  = 0;

    dino_motion_controller dut (
        .clk       (clk),
        .reset     (reset),
        .screenEnd (screenEnd),
        .up        (up),
        .down      (down),
        .halt      (halt),
        .dino_x    (dino_x),
        .dino_y    (dino_y),
        .ducking   (ducking),
        .airborne  (airborne)
    );

    always #5 clk = ~clk;

    // One frame boundary: screenEnd high for hi clk, then a short gap.
    // Returns at a negedge, after the tick edge.
    task automatic frame(input int hi);
        @(negedge clk);
        screenEnd = 1'b1;
        repeat (hi) @(negedge clk);
        screenEnd = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press_up();
        @(negedge clk);
        up = 1'b1;
        repeat (3) @(negedge clk);
        up = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dino_x !== 32'd100 || dino_y !== 32'd275 || airborne !== 1'b0 || ducking !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state x=%0d y=%0d air=%b duck=%b expected x=100 y=275 air=0 duck=0",
                     dino_x, dino_y, airborne, ducking);
        end
        for (int i = 0; i < 5; i++) begin
            frame(1);
            n_tests++;
            if (dino_x !== 32'd100 || dino_y !== 32'd275 || airborne !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_tick%0d x=%0d y=%0d air=%b expected x=100 y=275 air=0",
                         i, dino_x, dino_y, airborne);
            end
        end
    endtask

    task automatic test_full_jump();
        int exp_y;
        logic exp_air;
        press_up();
        exp_y = 275;
        for (int n = 1; n <= 36; n++) begin
            frame(1);
            if (n <= 18)      exp_y = exp_y - (19 - n);
            else if (n <= 35) exp_y = exp_y + (n - 18);
            else              exp_y = 275;
            exp_air = (n < 36);
            n_tests++;
            if (dino_y !== 32'(exp_y) || airborne !== exp_air) begin
                n_fail++;
                $display("FAIL jump_tick%0d y=%0d air=%b expected y=%0d air=%b",
                         n, dino_y, airborne, exp_y, exp_air);
            end
        end
        frame(1);
        n_tests++;
        if (dino_y !== 32'd275 || airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL no_rejump y=%0d air=%b expected y=275 air=0", dino_y, airborne);
        end
    endtask

    task automatic test_long_screen_end_and_halt();
        bit landed;
        press_up();
        frame(1);
        frame(8);
        n_tests++;
        if (dino_y !== 32'd240) begin
            n_fail++;
            $display("FAIL long_screenend y=%0d expected 240", dino_y);
        end
        @(negedge clk);
        halt = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 3; i++) frame(1);
        up = 1'b0;
        n_tests++;
        if (dino_y !== 32'd240 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_hold y=%0d air=%b expected y=240 air=1", dino_y, airborne);
        end
        @(negedge clk);
        halt = 1'b0;
        frame(1);
        n_tests++;
        if (dino_y !== 32'd224) begin
            n_fail++;
            $display("FAIL after_halt y=%0d expected 224", dino_y);
        end
        landed = 1'b0;
        for (int i = 0; i < 40 && !landed; i++) begin
            frame(1);
            if (!airborne) landed = 1'b1;
        end
        n_tests++;
        if (!landed || dino_y !== 32'd275) begin
            n_fail++;
            $display("FAIL halt_landing landed=%b y=%0d expected landed=1 y=275", landed, dino_y);
        end
    endtask

    task automatic test_duck();
        @(negedge clk);
        down = 1'b1;
        repeat (3) @(negedge clk);
        frame(1);
        n_tests++;
        if (ducking !== 1'b1 || airborne !== 1'b0 || dino_y !== 32'd275) begin
            n_fail++;
            $display("FAIL duck_enter duck=%b air=%b y=%0d expected duck=1 air=0 y=275",
                     ducking, airborne, dino_y);
        end
        press_up();
        frame(1);
        n_tests++;
        if (ducking !== 1'b1 || airborne !== 1'b0 || dino_y !== 32'd275) begin
            n_fail++;
            $display("FAIL duck_up_ignored duck=%b air=%b y=%0d expected duck=1 air=0 y=275",
                     ducking, airborne, dino_y);
        end
        @(negedge clk);
        down = 1'b0;
        repeat (3) @(negedge clk);
        frame(1);
        n_tests++;
        if (ducking !== 1'b0 || airborne !== 1'b0 || dino_y !== 32'd275) begin
            n_fail++;
            $display("FAIL duck_exit duck=%b air=%b y=%0d expected duck=0 air=0 y=275",
                     ducking, airborne, dino_y);
        end
        frame(1);
        n_tests++;
        if (airborne !== 1'b0 || dino_y !== 32'd275) begin
            n_fail++;
            $display("FAIL duck_no_stale_jump air=%b y=%0d expected air=0 y=275", airborne, dino_y);
        end
    endtask

    task automatic test_fastfall();
        int exp_y [5] = '{222, 236, 251, 267, 275};
        press_up();
        for (int i = 0; i < 4; i++) frame(1);
        n_tests++;
        if (dino_y !== 32'd209 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL ff_rise y=%0d air=%b expected y=209 air=1", dino_y, airborne);
        end
        @(negedge clk);
        down = 1'b1;
        repeat (3) @(negedge clk);
        frame(1);
        @(negedge clk);
        down = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (dino_y !== 32'd209 || airborne !== 1'b1 || ducking !== 1'b0) begin
            n_fail++;
            $display("FAIL ff_enter y=%0d air=%b duck=%b expected y=209 air=1 duck=0",
                     dino_y, airborne, ducking);
        end
        for (int i = 0; i < 5; i++) begin
            frame(1);
            n_tests++;
            if (dino_y !== 32'(exp_y[i]) || airborne !== (i < 4)) begin
                n_fail++;
                $display("FAIL ff_fall%0d y=%0d air=%b expected y=%0d air=%b",
                         i, dino_y, airborne, exp_y[i], (i < 4));
            end
        end
    endtask

    task automatic test_reset_mid_fall();
        press_up();
        for (int i = 0; i < 24; i++) frame(1);
        n_tests++;
        if (dino_y !== 32'd125 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_fall y=%0d air=%b expected y=125 air=1", dino_y, airborne);
        end
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (dino_y !== 32'd275 || airborne !== 1'b0 || ducking !== 1'b0 || dino_x !== 32'd100) begin
            n_fail++;
            $display("FAIL async_reset y=%0d air=%b duck=%b x=%0d expected y=275 air=0 duck=0 x=100",
                     dino_y, airborne, ducking, dino_x);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        frame(1);
        n_tests++;
        if (dino_y !== 32'd275 || airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset y=%0d air=%b expected y=275 air=0", dino_y, airborne);
        end
    endtask

    initial begin
        test_reset();
        test_full_jump();
        test_long_screen_end_and_halt();
        test_duck();
        test_fastfall();
        test_reset_mid_fall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
